// File: rtl/pong_game_ctrl_if.sv
// Pong controller bus: game events in from the field/paddle datapath, control
// strobes and score/status out from the controller.
//   master : field datapath side (drives events, observes control/status)
//   slave  : pong_game_ctrl side (observes events, drives control/status)
interface pong_game_ctrl_if #(
    parameter int unsigned SCORE_W = 4
) ();
    logic               frame_tick;
    logic               start;
    logic               miss_left;
    logic               miss_right;
    logic               paddle_hit;
    logic               ball_en;
    logic               ball_center;
    logic               serve_dir;
    logic [1:0]         speed;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [1:0]         winner;
    logic [1:0]         state;

    modport master (
        output frame_tick, start, miss_left, miss_right, paddle_hit,
        input  ball_en, ball_center, serve_dir, speed, score1, score2, winner, state
    );

    modport slave (
        input  frame_tick, start, miss_left, miss_right, paddle_hit,
        output ball_en, ball_center, serve_dir, speed, score1, score2, winner, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: IDLE -> SERVE (fixed frame countdown) -> PLAY -> point
// scoring -> SERVE or OVER. Tracks scores, serve direction, ball speed level
// and winner; issues ball update and re-centre strobes to the datapath.
// Ports:
//   CLK   : pixel clock, rising-edge
//   reset : asynchronous active-low reset
//   bus   : pong_game_ctrl_if.slave (events in, control/status out, all registered)
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned SCORE_W      = 4
) (
    input  logic            CLK,
    input  logic            reset,
    pong_game_ctrl_if.slave bus
);
    localparam int unsigned        FRAME_W    = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_M1     = SCORE_W'(WIN_SCORE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]         hit_cnt_q, hit_cnt_d;
    logic [1:0]         speed_q, speed_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               serve_dir_q, serve_dir_d;
    logic [1:0]         winner_q, winner_d;
    logic               ball_en_q, ball_en_d;
    logic               ball_center_q, ball_center_d;
    logic               start_rise_c;
    logic               serve_entry_c;

    assign start_rise_c = bus.start & ~start_q;

    // Next-state, counters and output strobes
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        hit_cnt_d     = hit_cnt_q;
        speed_d       = speed_q;
        score1_d      = score1_q;
        score2_d      = score2_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        serve_entry_c = 1'b0;
        ball_en_d     = 1'b0;
        ball_center_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise_c) begin
                    state_d     = ST_SERVE;
                    score1_d    = '0;
                    score2_d    = '0;
                    serve_dir_d = 1'b0;
                    speed_d     = 2'd0;
                    hit_cnt_d   = 2'd0;
                    winner_d    = 2'b00;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == LAST_FRAME) begin
                        state_d = ST_PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (bus.miss_left || bus.miss_right) begin
                    // Any point (including a void one) resets the rally speed
                    speed_d   = 2'd0;
                    hit_cnt_d = 2'd0;
                    state_d   = ST_SERVE;
                    if (bus.miss_right && !bus.miss_left) begin
                        score1_d    = score1_q + SCORE_W'(1);
                        serve_dir_d = 1'b1;
                        if (score1_q == WIN_M1) begin
                            state_d  = ST_OVER;
                            winner_d = 2'b01;
                        end
                    end else if (bus.miss_left && !bus.miss_right) begin
                        score2_d    = score2_q + SCORE_W'(1);
                        serve_dir_d = 1'b0;
                        if (score2_q == WIN_M1) begin
                            state_d  = ST_OVER;
                            winner_d = 2'b10;
                        end
                    end
                end else begin
                    if (bus.paddle_hit) begin
                        hit_cnt_d = hit_cnt_q + 2'd1;
                        if (hit_cnt_q == 2'd3 && speed_q != 2'd3) begin
                            speed_d = speed_q + 2'd1;
                        end
                    end
                    ball_en_d = bus.frame_tick;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every SERVE entry restarts the countdown and re-centres the ball
        if (state_d == ST_SERVE && state_q != ST_SERVE) begin
            serve_entry_c = 1'b1;
            frame_cnt_d   = '0;
        end
        ball_center_d = serve_entry_c;
    end

    // State and output registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            frame_cnt_q   <= '0;
            hit_cnt_q     <= 2'd0;
            speed_q       <= 2'd0;
            score1_q      <= '0;
            score2_q      <= '0;
            serve_dir_q   <= 1'b0;
            winner_q      <= 2'b00;
            ball_en_q     <= 1'b0;
            ball_center_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= bus.start;
            frame_cnt_q   <= frame_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            speed_q       <= speed_d;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            ball_en_q     <= ball_en_d;
            ball_center_q <= ball_center_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.ball_en     = ball_en_q;
    assign bus.ball_center = ball_center_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.speed       = speed_q;
    assign bus.score1      = score1_q;
    assign bus.score2      = score2_q;
    assign bus.winner      = winner_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a game-rule model is updated on every
// clock and compared with all outputs each cycle, plus literal spot checks.
module tb_pong_game_ctrl;
    localparam int unsigned WIN = 7;
    localparam int unsigned SF  = 60;
    localparam int unsigned SW  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pong_game_ctrl_if #(.SCORE_W(SW)) bus ();

    pong_game_ctrl #(
        .WIN_SCORE   (WIN),
        .SERVE_FRAMES(SF),
        .SCORE_W     (SW)
    ) dut (
        .CLK  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int ben_seen = 0;
    bit s_lvl = 1'b0;

    // Game model: phase 0 idle, 1 serve, 2 play, 3 over
    int m_state, m_s1, m_s2, m_hits, m_ticks, m_winner;
    bit m_dir, m_ben, m_bc, m_start_prev;

    function automatic int exp_speed(input int hits);
        return (hits / 4 > 3) ? 3 : hits / 4;
    endfunction

    task automatic m_reset();
        m_state = 0; m_s1 = 0; m_s2 = 0; m_hits = 0; m_ticks = 0; m_winner = 0;
        m_dir = 1'b0; m_ben = 1'b0; m_bc = 1'b0; m_start_prev = 1'b0;
    endtask

    task automatic m_new_serve();
        m_state = 1;
        m_ticks = 0;
        m_bc    = 1'b1;
    endtask

    task automatic model_update(input bit ft, input bit st, input bit ml, input bit mr, input bit ph);
        bit rise;
        if (!rst_n) begin
            m_reset();
            return;
        end
        rise = st && !m_start_prev;
        m_start_prev = st;
        m_ben = 1'b0;
        m_bc  = 1'b0;
        case (m_state)
            0, 3: if (rise) begin
                m_s1 = 0; m_s2 = 0; m_dir = 1'b0; m_hits = 0; m_winner = 0;
                m_new_serve();
            end
            1: if (ft) begin
                m_ticks++;
                if (m_ticks == SF) m_state = 2;
            end
            2: begin
                if (ml && mr) begin
                    m_hits = 0;
                    m_new_serve();
                end else if (mr) begin
                    m_s1++; m_dir = 1'b1; m_hits = 0;
                    if (m_s1 == WIN) begin m_state = 3; m_winner = 1; end
                    else m_new_serve();
                end else if (ml) begin
                    m_s2++; m_dir = 1'b0; m_hits = 0;
                    if (m_s2 == WIN) begin m_state = 3; m_winner = 2; end
                    else m_new_serve();
                end else begin
                    if (ph) m_hits++;
                    if (ft) m_ben = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cmp_all();
        chk("cyc_state",       int'(bus.state),       m_state);
        chk("cyc_ball_en",     int'(bus.ball_en),     int'(m_ben));
        chk("cyc_ball_center", int'(bus.ball_center), int'(m_bc));
        chk("cyc_serve_dir",   int'(bus.serve_dir),   int'(m_dir));
        chk("cyc_speed",       int'(bus.speed),       exp_speed(m_hits));
        chk("cyc_score1",      int'(bus.score1),      m_s1);
        chk("cyc_score2",      int'(bus.score2),      m_s2);
        chk("cyc_winner",      int'(bus.winner),      m_winner);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic step(input bit ft, input bit ml, input bit mr, input bit ph);
        bus.frame_tick = ft;
        bus.start      = s_lvl;
        bus.miss_left  = ml;
        bus.miss_right = mr;
        bus.paddle_hit = ph;
        @(posedge clk);
        model_update(ft, s_lvl, ml, mr, ph);
        @(negedge clk);
        cmp_all();
        if (bus.ball_en) ben_seen++;
    endtask

    task automatic serve_out();
        for (int i = 0; i < SF; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},  int'(bus.state),       0);
        chk({tag, "_score1"}, int'(bus.score1),      0);
        chk({tag, "_score2"}, int'(bus.score2),      0);
        chk({tag, "_speed"},  int'(bus.speed),       0);
        chk({tag, "_dir"},    int'(bus.serve_dir),   0);
        chk({tag, "_winner"}, int'(bus.winner),      0);
        chk({tag, "_ben"},    int'(bus.ball_en),     0);
        chk({tag, "_bc"},     int'(bus.ball_center), 0);
    endtask

    initial begin
        bus.frame_tick = 1'b0; bus.start = 1'b0; bus.miss_left = 1'b0;
        bus.miss_right = 1'b0; bus.paddle_hit = 1'b0;
        m_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("init");
        rst_n = 1'b1;

        // Start rise -> SERVE with one-cycle re-centre, then 60-tick countdown
        step(0, 0, 0, 0);
        chk("idle_no_start", int'(bus.state), 0);
        s_lvl = 1'b1;
        step(0, 0, 0, 0);
        chk("start_state", int'(bus.state), 1);
        chk("start_bc", int'(bus.ball_center), 1);
        step(0, 0, 0, 0);
        chk("bc_one_cycle", int'(bus.ball_center), 0);
        for (int i = 0; i < SF - 1; i++) step(1, 0, 0, 0);
        chk("serve_59", int'(bus.state), 1);
        step(1, 0, 0, 0);
        chk("serve_60_state", int'(bus.state), 2);
        chk("serve_60_no_ben", int'(bus.ball_en), 0);

        // Three ticks in PLAY -> three single-cycle ball_en pulses
        ben_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("ben_after_tick", int'(bus.ball_en), 1);
            step(0, 0, 0, 0);
            chk("ben_drops", int'(bus.ball_en), 0);
        end
        chk("ben_count", ben_seen, 3);

        // Start rise in PLAY is ignored
        s_lvl = 1'b0; step(0, 0, 0, 0);
        s_lvl = 1'b1; step(0, 0, 0, 0);
        chk("play_ignores_start", int'(bus.state), 2);

        // Speed ramp and saturation
        repeat (8) step(0, 0, 0, 1);
        chk("speed_8", int'(bus.speed), 2);
        repeat (4) step(0, 0, 0, 1);
        chk("speed_12", int'(bus.speed), 3);
        repeat (4) step(0, 0, 0, 1);
        chk("speed_sat", int'(bus.speed), 3);

        // Miss beats simultaneous hit
        step(0, 0, 1, 1);
        chk("mr_score1", int'(bus.score1), 1);
        chk("mr_dir", int'(bus.serve_dir), 1);
        chk("mr_speed", int'(bus.speed), 0);
        chk("mr_state", int'(bus.state), 1);

        // Events ignored in SERVE; void point with a tick in the same cycle
        step(0, 1, 0, 1);
        serve_out();
        step(1, 1, 1, 0);
        chk("void_s1", int'(bus.score1), 1);
        chk("void_s2", int'(bus.score2), 0);
        chk("void_state", int'(bus.state), 1);
        chk("void_no_ben", int'(bus.ball_en), 0);

        // Right player runs to the winning score
        for (int i = 0; i < 6; i++) begin
            serve_out();
            step(0, 1, 0, 0);
        end
        chk("s2_six", int'(bus.score2), 6);
        chk("s2_dir", int'(bus.serve_dir), 0);
        serve_out();
        step(0, 1, 0, 0);
        chk("win_s2", int'(bus.score2), 7);
        chk("win_state", int'(bus.state), 3);
        chk("win_winner", int'(bus.winner), 2);

        // OVER holds against misses and a held start
        step(0, 1, 0, 0); step(0, 0, 1, 0); step(1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        chk("over_s2_hold", int'(bus.score2), 7);
        chk("over_s1_hold", int'(bus.score1), 1);
        chk("over_state_hold", int'(bus.state), 3);
        s_lvl = 1'b0; step(0, 0, 0, 0);
        s_lvl = 1'b1; step(0, 0, 0, 0);
        chk("restart_state", int'(bus.state), 1);
        chk("restart_s1", int'(bus.score1), 0);
        chk("restart_s2", int'(bus.score2), 0);
        chk("restart_winner", int'(bus.winner), 0);

        // Reach PLAY with score1 = 3, then async reset mid-PLAY
        serve_out();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            serve_out();
        end
        chk("pre_rst_s1", int'(bus.score1), 3);
        chk("pre_rst_state", int'(bus.state), 2);
        step(1, 0, 0, 0);
        chk("pre_rst_ben", int'(bus.ball_en), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("arst");
        m_reset();
        @(negedge clk);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        s_lvl = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        s_lvl = 1'b1;
        step(0, 0, 0, 0);
        chk("post_rst_start", int'(bus.state), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIN_SCORE, 7, points needed to win the game; legal range 1..2^SCORE_W-1.
- SERVE_FRAMES, 60, number of frame_tick pulses spent in SERVE.
- SCORE_W, 4, width of each score counter.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK  in  1  pixel clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- start  in  1  level start/restart request from switch.
- miss_left  in  1  one-cycle pulse: ball left the field past the left paddle.
- miss_right  in  1  one-cycle pulse: ball left the field past the right paddle.
- paddle_hit  in  1  one-cycle pulse: ball struck either paddle.
- ball_en  out  1  one-cycle ball-position update strobe.
- ball_center  out  1  one-cycle strobe: datapath reloads ball to field centre.
- serve_dir  out  1  0 = serve toward left player, 1 = toward right player.
- speed  out  2  ball speed level 0..3.
- score1  out  SCORE_W  left player score.
- score2  out  SCORE_W  right player score.
- winner  out  2  00 none, 01 left player, 10 right player.
- state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 OVER.

Function
REQ-003 start SHALL be registered once; start_rise = start AND NOT start_q. Only start_rise SHALL be acted on.
REQ-004 The FSM SHALL have four states: IDLE, SERVE, PLAY and OVER, encoded as the state port.
REQ-005 IDLE with start_rise -> SERVE next cycle, with score1 = score2 = 0, serve_dir = 0, speed = 0, winner = 00.
REQ-006 OVER with start_rise -> SERVE, with the same clears as REQ-005.
REQ-007 start_rise in SERVE or PLAY SHALL be ignored.
REQ-008 ball_center SHALL be high for exactly the first cycle of every SERVE entry, and low at all other times.
REQ-009 SERVE SHALL count frame_tick pulses from 0 on entry.
REQ-010 On the SERVE_FRAMES-th frame_tick, the FSM SHALL go to PLAY on the next edge; no ball_en is issued for that tick.
REQ-011 In PLAY, ball_en SHALL be high for one cycle, the cycle after each frame_tick sampled in PLAY.
REQ-012 ball_en SHALL never be high outside PLAY.
REQ-013 In PLAY, each paddle_hit SHALL increment a 2-bit hit counter. When the counter wraps 3->0, speed SHALL increment, saturating at 3.
REQ-014 In PLAY, miss_right alone SHALL increment score1 and set serve_dir = 1.
REQ-015 In PLAY, miss_left alone SHALL increment score2 and set serve_dir = 0.
REQ-016 miss_left and miss_right in the same cycle SHALL be a void point: no score change, serve_dir unchanged, -> SERVE.
REQ-017 A miss SHALL take priority over a simultaneous paddle_hit; that hit is discarded.
REQ-018 After any point, speed and the hit counter SHALL clear to 0.
REQ-019 After a point, the FSM goes to OVER if the new score equals WIN_SCORE, else to SERVE.
REQ-020 On entering OVER, winner SHALL be set to 01 if score1 won, or 10 if score2 won.
REQ-021 Scores SHALL never wrap or exceed WIN_SCORE.
REQ-022 miss and paddle_hit inputs SHALL be ignored in IDLE, SERVE and OVER.
REQ-023 In OVER, score1, score2 and winner SHALL hold until start_rise or reset.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 When reset is low, the block SHALL immediately (asynchronously) force: state IDLE, all counters 0, scores 0, speed 0, serve_dir 0, winner 00, ball_en 0, ball_center 0, start_q 0.
REQ-026 Reset SHALL take effect from any state, including mid-SERVE countdown and mid-PLAY.
REQ-027 Operation SHALL resume on the first CLK edge after reset returns high.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset, then start 0->1 -> state 01 next cycle, ball_center one-cycle pulse; after 60 frame_ticks -> state 10, no ball_en for the 60th tick.
- In PLAY, 3 frame_ticks -> exactly 3 ball_en pulses, each one cycle after its tick. 8 paddle_hits -> speed 2. 4 more -> speed 3, which stays 3 after 4 further hits.
- miss_right with paddle_hit in the same cycle -> score1 1, serve_dir 1, speed 0, state 01.
- Both misses in the same cycle -> scores unchanged, state 01.
- score2 at 6, then miss_left -> score2 7, state 11, winner 10. Further misses -> no change. start held high -> no restart; start low then high -> scores 0, state 01.
- reset pulled low mid-PLAY with score1 3 -> all outputs at reset values without waiting for a CLK edge.
